// File: rtl/mem_access_pkg.sv
// Shared types for the LC3 memory-access controller: op codes, FSM states and the bus word.
package mem_access_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    OP_LD  = 2'd0,
    OP_ST  = 2'd1,
    OP_LDI = 2'd2,
    OP_STI = 2'd3
  } mem_op_t;

  typedef enum logic [2:0] {
    StIdle,
    StPtrRd,
    StDataRd,
    StDataWr,
    StResp
  } mem_state_t;

  function automatic logic is_indirect(mem_op_t op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

  function automatic logic is_bus_phase(mem_state_t st);
    return (st == StPtrRd) || (st == StDataRd) || (st == StDataWr);
  endfunction

endpackage

// File: rtl/lc3_mem_access_if.sv
// Request, data-memory bus and response signals of the memory-access controller.
interface lc3_mem_access_if;
  import mem_access_pkg::*;

  logic    req_valid;
  logic    req_ready;
  mem_op_t req_op;
  word_t   req_addr;
  word_t   req_wdata;

  word_t   Data_addr;
  word_t   Data_din;
  logic    Data_rd;
  word_t   Data_dout;
  logic    complete_data;

  logic    resp_valid;
  word_t   resp_rdata;
  logic    resp_err;

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, Data_dout, complete_data,
    output req_ready, Data_addr, Data_din, Data_rd, resp_valid, resp_rdata, resp_err
  );

  // Execute stage / memory side.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, Data_dout, complete_data,
    input  req_ready, Data_addr, Data_din, Data_rd, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_access_watchdog.sv
// Per-phase watchdog: counts cycles spent in a bus phase and flags the last allowed cycle.
module mem_access_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clock, reset, clear, enable};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // expired marks the TIMEOUT_CYCLES-th cycle of the phase; the counter saturates there.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && (cnt_q != CntLast)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired = enable && (cnt_q == CntLast);
  end

endmodule

// File: rtl/lc3_mem_access.sv
// LC3 memory-access controller: sequences LD/ST/LDI/STI onto the data bus with a per-phase watchdog.
module lc3_mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clock,
  input logic              reset,
  lc3_mem_access_if.slave  bus
);

  mem_state_t state_q, state_d;
  mem_op_t    op_q, op_d;
  word_t      wdata_q, wdata_d;
  word_t      addr_q, addr_d;
  word_t      din_q, din_d;
  logic       rd_q, rd_d;
  logic       resp_valid_q, resp_valid_d;
  word_t      rdata_q, rdata_d;
  logic       err_q, err_d;

  logic in_phase;
  logic phase_done;
  logic wd_clear;
  logic wd_expired;

  assign in_phase   = is_bus_phase(state_q);
  assign phase_done = in_phase && bus.complete_data;
  // Clearing on completion restarts the count for the data phase of LDI/STI.
  assign wd_clear   = !in_phase || phase_done;

  mem_access_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (in_phase),
    .expired(wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    din_d        = din_q;
    rd_d         = rd_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;

    unique case (state_q)
      StIdle: begin
        rd_d = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          wdata_d = bus.req_wdata;
          addr_d  = bus.req_addr;
          unique case (bus.req_op)
            OP_LD: state_d = StDataRd;
            OP_ST: begin
              state_d = StDataWr;
              rd_d    = 1'b0;
              din_d   = bus.req_wdata;
            end
            OP_LDI, OP_STI: state_d = StPtrRd;
            default: state_d = StIdle;
          endcase
        end
      end

      StPtrRd: begin
        if (bus.complete_data) begin
          addr_d = bus.Data_dout;
          if (op_q == OP_STI) begin
            state_d = StDataWr;
            rd_d    = 1'b0;
            din_d   = wdata_q;
          end else begin
            state_d = StDataRd;
          end
        end else if (wd_expired) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          rdata_d      = '0;
          err_d        = 1'b1;
        end
      end

      StDataRd: begin
        if (bus.complete_data) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          rdata_d      = bus.Data_dout;
          err_d        = 1'b0;
        end else if (wd_expired) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          rdata_d      = '0;
          err_d        = 1'b1;
        end
      end

      StDataWr: begin
        if (bus.complete_data || wd_expired) begin
          state_d      = StResp;
          rd_d         = 1'b1;
          resp_valid_d = 1'b1;
          rdata_d      = '0;
          err_d        = !bus.complete_data;
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        rd_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      op_q         <= OP_LD;
      wdata_q      <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      rd_q         <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      rd_q         <= rd_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.Data_addr  = addr_q;
  assign bus.Data_din   = din_q;
  assign bus.Data_rd    = rd_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: doc/lc3_mem_access.md
# lc3_mem_access

Memory-access controller for the LC3 core: accepts one load/store request per transaction from the execute stage and sequences it onto the data-memory bus. It drives Data_addr, Data_din and Data_rd, and waits for complete_data from memory. For indirect operations (LDI/STI) it performs the pointer read first. It returns read data, or a timeout error, to writeback through a single-cycle response pulse.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 64: cycles allowed per access phase before abort; 0 disables the watchdog.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request strobe from execute.
- req_ready  out  1  high only in IDLE; a request is accepted on clock when req_valid && req_ready.
- req_op  in  2  operation code: 0 = LD (read), 1 = ST (write), 2 = LDI, 3 = STI.
- req_addr  in  16  effective address; for LDI/STI this is the pointer address.
- req_wdata  in  16  store data, used by ST/STI.
- Data_addr  out  16  memory address.
- Data_din  out  16  write data to memory.
- Data_rd  out  1  1 = read, 0 = write.
- Data_dout  in  16  read data from memory.
- complete_data  in  1  memory completion pulse for the current phase.
- resp_valid  out  1  single-cycle response pulse.
- resp_rdata  out  16  load result; 0 for stores and on error.
- resp_err  out  1  qualified by resp_valid; 1 = phase timed out.

## Operation
- States: IDLE, PTR_RD, DATA_RD, DATA_WR, RESP.
- Acceptance: req_op, req_addr and req_wdata are latched on acceptance. Next state depends on the op:
  - LD → DATA_RD, Data_addr = req_addr.
  - ST → DATA_WR, Data_addr = req_addr, Data_din = req_wdata.
  - LDI/STI → PTR_RD, Data_addr = req_addr.
- PTR_RD: Data_rd = 1. On complete_data, Data_dout is captured as the new address. The FSM then moves to DATA_RD (LDI) or DATA_WR (STI), and Data_addr takes the captured value in the next cycle.
- DATA_RD: Data_rd = 1. On complete_data, Data_dout is captured into resp_rdata and the FSM moves to RESP.
- DATA_WR: Data_rd = 0, Data_din held. On complete_data the FSM moves to RESP with resp_rdata = 0.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Phase completion: a phase completes on the first cycle complete_data is sampled high while in that phase, including the phase's first cycle (zero-wait memory).
  - complete_data seen in IDLE or RESP is ignored.
  - Memory must pulse complete_data once per phase.
- Bus stability: Data_addr, Data_din and Data_rd are registered and stay stable for the whole phase.
- IDLE bus values: Data_rd = 1, Data_addr/Data_din hold their last values. No write can occur outside DATA_WR.
- Watchdog: a per-phase counter clears on phase entry.
  - When it reaches TIMEOUT_CYCLES without complete_data, the FSM goes to RESP with resp_err = 1 and resp_rdata = 0.
  - An STI pointer timeout skips the write.
  - If complete_data arrives in the same cycle the counter expires, completion wins.
- req_valid while busy: ignored (req_ready = 0), never queued.

## Timing
- Reset values, applied on clock when reset = 0:
  - State = IDLE, req_ready = 1, Data_rd = 1.
  - Data_addr, Data_din = 16'h0000.
  - resp_valid = 0, resp_rdata = 16'h0000, resp_err = 0, watchdog = 0.
- Reset mid-transaction aborts immediately. No response is issued and no write completes after reset.
- Latency with zero-wait memory, request accepted at cycle T:
  - LD/ST: access in T+1, resp_valid in T+2.
  - LDI/STI: pointer read in T+1, data phase in T+2, resp_valid in T+3.
- Each wait cycle of memory adds one cycle per phase.
- Back-to-back throughput: next accept at the cycle after RESP. A minimum of 3 cycles per LD/ST.
- Addresses pass through unmodified; no arithmetic is done on the address.

## Structure
- Shared package mem_access_pkg holds:
  - mem_op_t enum (OP_LD = 0, OP_ST = 1, OP_LDI = 2, OP_STI = 3).
  - mem_state_t enum.
  - The 16-bit word typedef.
- Sub-module mem_access_watchdog: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES, disabled when the parameter is 0.
- The top level contains the FSM and output registers.

## Test plan
- LD addr 16'h3000, memory returns 16'hBEEF with zero wait → Data_rd = 1 and Data_addr = 16'h3000 at T+1; resp_valid at T+2 with resp_rdata = 16'hBEEF, resp_err = 0.
- ST addr 16'h3004, wdata 16'h1234, memory waits 3 cycles → Data_rd = 0 and Data_din = 16'h1234 stable for 4 cycles; single resp_valid with resp_rdata = 0.
- LDI pointer 16'h3010, memory returns 16'h4000 then 16'h00AA → second phase shows Data_addr = 16'h4000; resp_rdata = 16'h00AA at T+3.
- STI with TIMEOUT_CYCLES = 8 and no complete_data in the pointer phase → resp_err = 1 after 8 cycles; Data_rd never goes 0.
- reset = 0 in the second cycle of a waiting ST → next cycle is IDLE with reset values; a complete_data pulse arriving later produces no resp_valid.
- req_valid held high during an active LD, then a second request → the second request is accepted only at the cycle after RESP; exactly two responses are produced, in order.
